// File: rtl/fifo_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared types, constants and helpers for the FIFO write-port arbiter and
// the round-robin picker.
//   arb_state_e : arbiter sequencing states (IDLE, ISSUE, WAIT, BACKOFF)
//   DEF_*       : default parameter values and statistics counter width
//   ptr_inc     : advance a round-robin pointer, wrapping modulo n
//   sat_inc     : saturating increment for statistics counters
// ---------------------------------------------------------------------------
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 15;
    localparam int unsigned STAT_W      = 16;

    // Pointer helper width covers the largest supported requester count (8).
    localparam int unsigned PTR_W = 3;

    // Next round-robin pointer: ptr + 1, wrapping to 0 at n.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned     n = DEF_NUM_REQ);
        logic [PTR_W-1:0] nxt;
        if ((32'(ptr) + 32'd1) >= n) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STAT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after the pointer, wrapping around. Shared with the read-side scheduler.
//   req_i   [N-1:0]     request vector
//   ptr_i   [IDX_W-1:0] highest-priority index this round
//   valid_o             at least one request asserted
//   idx_o   [IDX_W-1:0] chosen index (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int               pos_s;
    logic [IDX_W-1:0] idx_k_s;

    // Scan offsets from farthest to nearest so the request closest to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = {IDX_W{1'b0}};
        pos_s   = 0;
        idx_k_s = {IDX_W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            pos_s   = ((int'(ptr_i) + k) >= N) ? (int'(ptr_i) + k - N) : (int'(ptr_i) + k);
            idx_k_s = IDX_W'(pos_s);
            valid_o = valid_o | req_i[idx_k_s];
            idx_o   = req_i[idx_k_s] ? idx_k_s : idx_o;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single FIFO write port among NUM_REQ producers with round-robin
// arbitration and sequences every write as issue -> wait for ack ->
// (backoff and retry on overflow). All outputs are registered.
//
// Ports
//   clk, rst (async, active high)
//   req          [NUM_REQ]            per-requester request level
//   req_data     [NUM_REQ*FIFO_WIDTH] packed data, slice i for requester i
//   req_done     [NUM_REQ]            one-cycle pulse on accepted write
//   fifo_wr_en, fifo_data_in          FIFO write side
//   fifo_full, fifo_wr_ack, fifo_overflow  FIFO status (ack/overflow are
//                                     valid the cycle after wr_en)
//   grant_id                          index owning the port
//   busy                              state is not IDLE
//   err_timeout                       sticky WAIT timeout flag
//
// Optional build macro FIFO_WR_ARB_STATS_EN adds:
//   stat_grants  [NUM_REQ*16] per-requester saturating completed-write count
//   stat_retries [16]         saturating count of BACKOFF entries
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = 16,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err_timeout
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     stat_grants,
    output logic [STAT_W-1:0]             stat_retries
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       grant_q;
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic [NUM_REQ-1:0]     req_done_q;
    logic                   wr_en_q;
    logic                   busy_q;
    logic                   err_q;
    logic [FIFO_WIDTH-1:0]  data_q;

    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [FIFO_WIDTH-1:0]  pick_data_s;
    logic [IDX_W-1:0]       ptr_next_s;
    logic                   ack_evt_s;
    logic                   retry_evt_s;
    logic                   tmo_evt_s;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // WAIT-state events and data/pointer selection feeding the FSM.
    always_comb begin
        pick_data_s = FIFO_WIDTH'(req_data >> (int'(pick_idx_s) * FIFO_WIDTH));
        ptr_next_s  = IDX_W'(ptr_inc(PTR_W'(grant_q), NUM_REQ));
        // Ack has priority over overflow when both arrive together.
        ack_evt_s   = (state_q == WAIT) && fifo_wr_ack;
        retry_evt_s = (state_q == WAIT) && !fifo_wr_ack && fifo_overflow;
        tmo_evt_s   = (state_q == WAIT) && !fifo_wr_ack && !fifo_overflow &&
                      (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Arbitration/sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= {IDX_W{1'b0}};
            grant_q    <= {IDX_W{1'b0}};
            tmo_cnt_q  <= {CNT_W{1'b0}};
            req_done_q <= {NUM_REQ{1'b0}};
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= {FIFO_WIDTH{1'b0}};
        end else begin
            req_done_q <= {NUM_REQ{1'b0}};
            case (state_q)
                IDLE: begin
                    if (pick_valid_s && !fifo_full) begin
                        grant_q <= pick_idx_s;
                        data_q  <= pick_data_s;
                        wr_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    wr_en_q   <= 1'b0;
                    busy_q    <= 1'b1;
                    tmo_cnt_q <= {CNT_W{1'b0}};
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (ack_evt_s) begin
                        req_done_q[grant_q] <= 1'b1;
                        ptr_q               <= ptr_next_s;
                        busy_q              <= 1'b0;
                        state_q             <= IDLE;
                    end else if (retry_evt_s) begin
                        // Grant and data stay latched for the reissue.
                        busy_q  <= 1'b1;
                        state_q <= BACKOFF;
                    end else if (tmo_evt_s) begin
                        // Pointer untouched so the same requester retries first.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        busy_q    <= 1'b1;
                    end
                end
                BACKOFF: begin
                    busy_q <= 1'b1;
                    if (!fifo_full) begin
                        wr_en_q <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
                default: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_done     = req_done_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] grants_q [NUM_REQ];
    logic [STAT_W-1:0] retries_q;

    // Completed-write and retry counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_q[i] <= {STAT_W{1'b0}};
            end
            retries_q <= {STAT_W{1'b0}};
        end else begin
            if (ack_evt_s) begin
                grants_q[grant_q] <= sat_inc(grants_q[grant_q]);
            end else begin
                grants_q[grant_q] <= grants_q[grant_q];
            end
            if (retry_evt_s) begin
                retries_q <= sat_inc(retries_q);
            end else begin
                retries_q <= retries_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_out
        assign stat_grants[g*STAT_W +: STAT_W] = grants_q[g];
    end
    assign stat_retries = retries_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter with a small registered FIFO responder
// (ack or overflow the cycle after wr_en, or silence).
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FW      = 16;
    localparam int TMO     = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*FW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_done;
    logic                   fifo_wr_en;
    logic [FW-1:0]          fifo_data_in;
    logic                   fifo_full;
    logic                   fifo_wr_ack;
    logic                   fifo_overflow;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   err_timeout;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]  stat_grants;
    logic [15:0]            stat_retries;
`endif

    // Responder controls
    logic ovf_next = 1'b0;
    logic silent   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_done      (req_done),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_timeout   (err_timeout)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_grants   (stat_grants),
        .stat_retries  (stat_retries)
`endif
    );

    always #5 clk = ~clk;

    // Registered FIFO response model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_ack   <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            fifo_wr_ack   <= fifo_wr_en && !ovf_next && !silent;
            fifo_overflow <= fifo_wr_en && ovf_next;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        int         exp_g;

        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        step();
        step();
        check_eq("rst_wr_en",    32'(fifo_wr_en),   32'd0);
        check_eq("rst_busy",     32'(busy),         32'd0);
        check_eq("rst_grant",    32'(grant_id),     32'd0);
        check_eq("rst_done",     32'(req_done),     32'd0);
        check_eq("rst_err",      32'(err_timeout),  32'd0);
        check_eq("rst_data",     32'(fifo_data_in), 32'd0);
        rst = 1'b0;

        // Single requester 2, empty FIFO
        req      = 4'b0100;
        req_data = 64'h0000_A5A5_0000_0000;
        step();
        check_eq("t1_wr_en",  32'(fifo_wr_en),   32'd1);
        check_eq("t1_data",   32'(fifo_data_in), 32'hA5A5);
        check_eq("t1_grant",  32'(grant_id),     32'd2);
        check_eq("t1_busy",   32'(busy),         32'd1);
        step();
        check_eq("t1_wr_off", 32'(fifo_wr_en),   32'd0);
        check_eq("t1_nodone", 32'(req_done),     32'd0);
        check_eq("t1_grant2", 32'(grant_id),     32'd2);
        step();
        check_eq("t1_done",   32'(req_done),     32'h4);
        check_eq("t1_grant3", 32'(grant_id),     32'd2);
        req = 4'b0000;
        step();
        check_eq("t1_pulse",  32'(req_done),     32'd0);
        check_eq("t1_idle",   32'(busy),         32'd0);

        // All four requesting: grant order 0,1,2,3,0, one done per 3 cycles
        do_reset();
        req_data = 64'h1003_1002_1001_1000;
        req      = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = t % 4;
            step();
            check_eq("t2_wr_en",  32'(fifo_wr_en),   32'd1);
            check_eq("t2_grant",  32'(grant_id),     32'(exp_g));
            check_eq("t2_data",   32'(fifo_data_in), 32'h1000 + 32'(exp_g));
            check_eq("t2_done0",  32'(req_done),     32'd0);
            step();
            check_eq("t2_done1",  32'(req_done),     32'd0);
            step();
            check_eq("t2_done",   32'(req_done),     32'd1 << exp_g);
        end
        req = 4'b0000;
        step();
        step();

        // Overflow on first write, FIFO full for 4 cycles, then reissue
        do_reset();
        req      = 4'b0010;
        req_data = 64'h0000_0000_5A3C_0000;
        ovf_next = 1'b1;
        step();
        check_eq("t3_wr_en",  32'(fifo_wr_en),   32'd1);
        check_eq("t3_grant",  32'(grant_id),     32'd1);
        step();
        ovf_next  = 1'b0;
        fifo_full = 1'b1;
        step();
        check_eq("t3_bo_busy", 32'(busy),        32'd1);
        check_eq("t3_bo_wr",   32'(fifo_wr_en),  32'd0);
        check_eq("t3_bo_done", 32'(req_done),    32'd0);
        step();
        step();
        step();
        check_eq("t3_bo_hold", 32'(fifo_wr_en),  32'd0);
        check_eq("t3_bo_gnt",  32'(grant_id),    32'd1);
        fifo_full = 1'b0;
        step();
        check_eq("t3_re_wr",   32'(fifo_wr_en),   32'd1);
        check_eq("t3_re_data", 32'(fifo_data_in), 32'h5A3C);
        check_eq("t3_re_gnt",  32'(grant_id),     32'd1);
        step();
        check_eq("t3_nodone",  32'(req_done),     32'd0);
        step();
        check_eq("t3_done",    32'(req_done),     32'h2);
        req = 4'b0000;
`ifdef FIFO_WR_ARB_STATS_EN
        check_eq("t3_retries", 32'(stat_retries),       32'd1);
        check_eq("t3_grants1", 32'(stat_grants[31:16]), 32'd1);
`endif
        step();

        // Silent FIFO: timeout, pointer unchanged, same requester regranted
        do_reset();
        silent   = 1'b1;
        req      = 4'b1100;
        req_data = 64'h3333_2222_0000_0000;
        step();
        check_eq("t4_grant",   32'(grant_id),     32'd2);
        check_eq("t4_data",    32'(fifo_data_in), 32'h2222);
        acc = 4'b0000;
        for (int k = 1; k <= TMO; k++) begin
            step();
            acc = acc | req_done;
        end
        check_eq("t4_err_pre", 32'(err_timeout), 32'd0);
        check_eq("t4_busy",    32'(busy),        32'd1);
        step();
        acc = acc | req_done;
        check_eq("t4_err",     32'(err_timeout), 32'd1);
        check_eq("t4_idle",    32'(busy),        32'd0);
        check_eq("t4_nodone",  32'(acc),         32'd0);
        silent = 1'b0;
        step();
        check_eq("t4_regrant", 32'(grant_id),    32'd2);
        check_eq("t4_rewr",    32'(fifo_wr_en),  32'd1);
        step();
        step();
        check_eq("t4_done",    32'(req_done),    32'h4);
        check_eq("t4_sticky",  32'(err_timeout), 32'd1);
        req = 4'b0000;
        step();

        // Reset during ISSUE
        do_reset();
        req      = 4'b0010;
        req_data = 64'h4444_3333_2222_1111;
        step();
        step();
        step();
        check_eq("t5_pre_done", 32'(req_done),   32'h2);
        req = 4'b0101;
        step();
        check_eq("t5_issue",   32'(fifo_wr_en),  32'd1);
        check_eq("t5_grant2",  32'(grant_id),    32'd2);
        #1 rst = 1'b1;
        #1;
        check_eq("t5_rst_wr",  32'(fifo_wr_en),  32'd0);
        check_eq("t5_rst_bsy", 32'(busy),        32'd0);
        check_eq("t5_rst_gnt", 32'(grant_id),    32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("t5_first",   32'(grant_id),     32'd0);
        check_eq("t5_wr",      32'(fifo_wr_en),   32'd1);
        check_eq("t5_data",    32'(fifo_data_in), 32'h1111);
        step();
        step();
        check_eq("t5_done",    32'(req_done),     32'h1);
        req = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
